// File: rtl/crtc_char_fetch_if.sv
// Bus between the CRTC timing/address source, the video/font memories and
// the character fetch / pixel shifter block.
interface crtc_char_fetch_if;
  // CRTC timing and address
  logic        clken;
  logic        pixen;
  logic        de;
  logic        hsync;
  logic        vsync;
  logic        cursor;
  logic        gfx;
  logic [13:0] ma;
  logic [4:0]  ra;
  // Video RAM port
  logic [13:0] vaddr;
  logic        vrd;
  logic [7:0]  vdata;
  // Font ROM port
  logic [10:0] faddr;
  logic        frd;
  logic [7:0]  fdata;
  // Pixel stream and re-timed sync
  logic        pix;
  logic        de_o;
  logic        hsync_o;
  logic        vsync_o;
  logic        overrun;

  // Timing source and memories
  modport master (
    output clken, pixen, de, hsync, vsync, cursor, gfx, ma, ra, vdata, fdata,
    input  vaddr, vrd, faddr, frd, pix, de_o, hsync_o, vsync_o, overrun
  );

  // Character fetch block
  modport slave (
    input  clken, pixen, de, hsync, vsync, cursor, gfx, ma, ra, vdata, fdata,
    output vaddr, vrd, faddr, frd, pix, de_o, hsync_o, vsync_o, overrun
  );
endinterface

// File: rtl/crtc_char_fetch.sv
// Character fetch and pixel shifter: on each character strobe, fetch the
// character code from video RAM and its font row from the font ROM (or the
// raw bitmap byte in GFX mode), then shift it out MSB-first during the next
// character period with DE/HSYNC/VSYNC delayed to match.
module crtc_char_fetch #(
  parameter bit INVERT_CURSOR = 1'b1
) (
  input logic              clk,
  input logic              rst,
  crtc_char_fetch_if.slave bus
);

  typedef enum logic [2:0] {IDLE, VREQ, VWAIT, FREQ, FWAIT, READY} state_t;

  state_t      state;
  state_t      state_nxt;

  logic [13:0] vaddr;
  logic [10:0] faddr;
  logic [2:0]  ra_q;
  logic        gfx_q;
  logic [7:0]  pending;
  logic        pend_cur;
  logic [7:0]  sr;
  logic        de_q;
  logic        hs_q;
  logic        vs_q;
  logic        de_o;
  logic        hs_o;
  logic        vs_o;
  logic        overrun;
  logic        busy;
  logic        unused_ra;

  // Only the low three raster bits select a font row.
  assign unused_ra = ^bus.ra[4:3];

  assign busy = (state == VREQ) || (state == VWAIT) ||
                (state == FREQ) || (state == FWAIT);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next state: a character strobe always restarts the sequence
  always_comb begin
    state_nxt = state;
    if (bus.clken) begin
      state_nxt = bus.de ? VREQ : IDLE;
    end else begin
      unique case (state)
        VREQ:    state_nxt = VWAIT;
        VWAIT:   state_nxt = gfx_q ? READY : FREQ;
        FREQ:    state_nxt = FWAIT;
        FWAIT:   state_nxt = READY;
        default: state_nxt = state;
      endcase
    end
  end

  // Fetch datapath: capture request, latch code/font/bitmap byte
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vaddr    <= '0;
      faddr    <= '0;
      ra_q     <= '0;
      gfx_q    <= 1'b0;
      pending  <= '0;
      pend_cur <= 1'b0;
    end else if (bus.clken) begin
      if (bus.de) begin
        vaddr    <= bus.ma;
        ra_q     <= bus.ra[2:0];
        gfx_q    <= bus.gfx;
        pend_cur <= bus.cursor;
      end else begin
        pending  <= '0;
        pend_cur <= 1'b0;
      end
    end else begin
      if (state == VWAIT) begin
        if (gfx_q) pending <= bus.vdata;
        else       faddr   <= {bus.vdata, ra_q};
      end
      if (state == FWAIT) pending <= bus.fdata;
    end
  end

  // Output stage: load/shift pixels, delay timing by one character, sticky overrun
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sr      <= '0;
      de_q    <= 1'b0;
      hs_q    <= 1'b0;
      vs_q    <= 1'b0;
      de_o    <= 1'b0;
      hs_o    <= 1'b0;
      vs_o    <= 1'b0;
      overrun <= 1'b0;
    end else if (bus.clken) begin
      // An unfinished fetch shows as a blank cell rather than stale data.
      sr      <= busy ? '0 : (pending ^ {8{pend_cur & INVERT_CURSOR}});
      if (busy) overrun <= 1'b1;
      de_o    <= de_q;
      hs_o    <= hs_q;
      vs_o    <= vs_q;
      de_q    <= bus.de;
      hs_q    <= bus.hsync;
      vs_q    <= bus.vsync;
    end else if (bus.pixen) begin
      sr <= {sr[6:0], 1'b0};
    end
  end

  assign bus.vaddr   = vaddr;
  assign bus.faddr   = faddr;
  assign bus.vrd     = (state == VREQ);
  assign bus.frd     = (state == FREQ);
  assign bus.pix     = sr[7] & de_o;
  assign bus.de_o    = de_o;
  assign bus.hsync_o = hs_o;
  assign bus.vsync_o = vs_o;
  assign bus.overrun = overrun;

endmodule

// File: tb/tb_crtc_char_fetch.sv
// Bench for crtc_char_fetch: directed character sequence with a scoreboard
// of expected memory addresses and per-character output windows.
module tb_crtc_char_fetch;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  crtc_char_fetch_if bus ();
  crtc_char_fetch_if bus0 ();

  crtc_char_fetch #(.INVERT_CURSOR(1'b1)) dut (.clk(clk), .rst(rst), .bus(bus));
  crtc_char_fetch #(.INVERT_CURSOR(1'b0)) dut0 (.clk(clk), .rst(rst), .bus(bus0));

  // Second instance sees identical stimulus and memory data.
  assign bus0.clken  = bus.clken;
  assign bus0.pixen  = bus.pixen;
  assign bus0.de     = bus.de;
  assign bus0.hsync  = bus.hsync;
  assign bus0.vsync  = bus.vsync;
  assign bus0.cursor = bus.cursor;
  assign bus0.gfx    = bus.gfx;
  assign bus0.ma     = bus.ma;
  assign bus0.ra     = bus.ra;
  assign bus0.vdata  = bus.vdata;
  assign bus0.fdata  = bus.fdata;

  // Memories: data valid one clock after the strobe, junk otherwise.
  logic [7:0] vram_val;
  logic [7:0] font_val;
  always @(posedge clk) begin
    bus.vdata <= bus.vrd ? vram_val : 8'h5A;
    bus.fdata <= bus.frd ? font_val : 8'h3C;
  end

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", name, got, exp);
    end
  endtask

  typedef struct {
    logic [7:0] pix1;
    logic [7:0] pix0;
    logic       de;
    logic       hs;
    logic       vs;
    logic       ovr;
  } win_t;

  win_t        wq[$];
  logic [13:0] vq[$];
  logic [10:0] fq[$];

  // Monitor state
  win_t       cur_w;
  bit         win_on = 1'b0;
  int         cnt;
  logic [7:0] b1;
  logic [7:0] b0;

  task close_win();
    logic [7:0] m;
    logic [7:0] g1;
    logic [7:0] g0;
    m  = 8'hFF << (8 - cnt);
    g1 = b1 << (8 - cnt);
    g0 = b0 << (8 - cnt);
    check("pix_inv", g1, cur_w.pix1 & m);
    check("pix_noinv", g0, cur_w.pix0 & m);
  endtask

  always @(posedge clk) begin
    #1;
    if (rst) begin
      win_on = 1'b0;
    end else begin
      if (bus.clken) begin
        if (win_on) close_win();
        win_on = 1'b0;
        if (wq.size() == 0) begin
          total++;
          bad++;
          $display("FAIL sb_window: got=empty expected=entry");
        end else begin
          cur_w  = wq.pop_front();
          win_on = 1'b1;
          cnt    = 0;
          b1     = '0;
          b0     = '0;
          check("de_o", bus.de_o, cur_w.de);
          check("hsync_o", bus.hsync_o, cur_w.hs);
          check("vsync_o", bus.vsync_o, cur_w.vs);
          check("overrun", bus.overrun, cur_w.ovr);
        end
      end
      if (win_on) begin
        b1 = {b1[6:0], bus.pix};
        b0 = {b0[6:0], bus0.pix};
        cnt++;
        if (cnt == 8) begin
          close_win();
          win_on = 1'b0;
        end
      end
    end
    if (bus.vrd) begin
      if (vq.size() == 0) begin
        total++;
        bad++;
        $display("FAIL vrd_unexpected: got=vrd vaddr=%0h expected=no vrd", bus.vaddr);
      end else check("vaddr", bus.vaddr, vq.pop_front());
    end
    if (bus.frd) begin
      if (fq.size() == 0) begin
        total++;
        bad++;
        $display("FAIL frd_unexpected: got=frd faddr=%0h expected=no frd", bus.faddr);
      end else check("faddr", bus.faddr, fq.pop_front());
    end
  end

  // One character: strobe at the current negedge, then per-1 idle cycles.
  task automatic send(input bit de, input bit hs, input bit vs, input bit cur, input bit gfx,
                      input logic [13:0] ma, input logic [4:0] ra,
                      input logic [7:0] vv, input logic [7:0] fv, input int per,
                      input logic [7:0] e1, input logic [7:0] e0,
                      input bit ede, input bit ehs, input bit evs, input bit eovr);
    win_t w;
    w.pix1 = e1;
    w.pix0 = e0;
    w.de   = ede;
    w.hs   = ehs;
    w.vs   = evs;
    w.ovr  = eovr;
    wq.push_back(w);
    if (de) vq.push_back(ma);
    if (de && !gfx) fq.push_back({vv, ra[2:0]});
    vram_val   = vv;
    font_val   = fv;
    bus.clken  = 1'b1;
    bus.de     = de;
    bus.hsync  = hs;
    bus.vsync  = vs;
    bus.cursor = cur;
    bus.gfx    = gfx;
    bus.ma     = ma;
    bus.ra     = ra;
    @(negedge clk);
    bus.clken = 1'b0;
    repeat (per - 1) @(negedge clk);
  endtask

  task check_reset_outputs(input string tag);
    check({tag, "_pix"}, bus.pix, 1'b0);
    check({tag, "_de_o"}, bus.de_o, 1'b0);
    check({tag, "_hsync_o"}, bus.hsync_o, 1'b0);
    check({tag, "_vsync_o"}, bus.vsync_o, 1'b0);
    check({tag, "_vrd"}, bus.vrd, 1'b0);
    check({tag, "_frd"}, bus.frd, 1'b0);
    check({tag, "_vaddr"}, bus.vaddr, 14'h0);
    check({tag, "_faddr"}, bus.faddr, 11'h0);
    check({tag, "_overrun"}, bus.overrun, 1'b0);
  endtask

  initial begin
    rst        = 1'b1;
    bus.clken  = 1'b0;
    bus.pixen  = 1'b1;
    bus.de     = 1'b0;
    bus.hsync  = 1'b0;
    bus.vsync  = 1'b0;
    bus.cursor = 1'b0;
    bus.gfx    = 1'b0;
    bus.ma     = '0;
    bus.ra     = '0;
    vram_val   = '0;
    font_val   = '0;
    repeat (3) @(negedge clk);
    check_reset_outputs("rst");
    rst = 1'b0;
    @(negedge clk);

    //    de hs vs cu gf ma        ra     vram   font  per  exp_inv exp_noinv de hs vs ovr
    send(1, 0, 0, 0, 0, 14'h0123, 5'd2,  8'h41, 8'hA5, 8,  8'h00,  8'h00,    0, 0, 0, 0); // text fetch
    send(1, 0, 0, 1, 0, 14'h0124, 5'd2,  8'h41, 8'hA5, 8,  8'hA5,  8'hA5,    1, 0, 0, 0); // cursor cell
    send(1, 0, 0, 0, 1, 14'h0200, 5'd0,  8'hF0, 8'h00, 8,  8'h5A,  8'hA5,    1, 0, 0, 0); // gfx byte
    send(0, 1, 0, 0, 0, 14'h0300, 5'd0,  8'h00, 8'h00, 8,  8'hF0,  8'hF0,    1, 0, 0, 0); // border+hsync
    send(1, 0, 1, 1, 0, 14'h3FFF, 5'h1F, 8'hFF, 8'h81, 8,  8'h00,  8'h00,    0, 1, 0, 0); // max addrs
    send(0, 0, 0, 0, 0, 14'h0000, 5'd0,  8'h00, 8'h00, 8,  8'h7E,  8'h81,    1, 0, 1, 0);
    send(1, 0, 0, 0, 0, 14'h0010, 5'd1,  8'h12, 8'h3C, 4,  8'h00,  8'h00,    0, 0, 0, 0); // period 4
    send(1, 0, 0, 0, 0, 14'h0011, 5'd1,  8'h13, 8'h66, 4,  8'h00,  8'h00,    1, 0, 0, 1); // overrun
    send(1, 0, 0, 0, 0, 14'h0012, 5'd0,  8'h20, 8'hC3, 8,  8'h00,  8'h00,    1, 0, 0, 1); // overrun
    send(1, 0, 0, 0, 0, 14'h0013, 5'd0,  8'h21, 8'h99, 8,  8'hC3,  8'hC3,    1, 0, 0, 1); // sticky
    // Reset while the font request is on the bus.
    send(1, 0, 0, 0, 0, 14'h0055, 5'd3,  8'h77, 8'hE7, 3,  8'h99,  8'h99,    1, 0, 0, 1);
    check("frd_before_rst", bus.frd, 1'b1);
    rst = 1'b1;
    #1;
    check_reset_outputs("async_rst");
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    send(1, 0, 0, 0, 0, 14'h00AB, 5'd4,  8'h5C, 8'h3C, 8,  8'h00,  8'h00,    0, 0, 0, 0); // clean fetch
    send(0, 0, 0, 0, 0, 14'h0000, 5'd0,  8'h00, 8'h00, 8,  8'h3C,  8'h3C,    1, 0, 0, 0);
    send(0, 0, 0, 0, 0, 14'h0000, 5'd0,  8'h00, 8'h00, 8,  8'h00,  8'h00,    0, 0, 0, 0);
    repeat (2) @(negedge clk);

    check("vaddr_queue_left", vq.size(), 0);
    check("faddr_queue_left", fq.size(), 0);
    check("window_queue_left", wq.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
